uart_rx_16: RTL
===============

Name: uart_rx_16

Overview:
16-bit-word UART receiver, the receive-side counterpart of the team's 16-bit transmitter. Frame format: 1 start bit (0), 16 data bits LSB first, 1 stop bit (1), no parity. The block deserialises frames from the host link into 16-bit words for the Mandelbrot control path. It emits a one-cycle valid pulse per good frame and a one-cycle error pulse per bad frame.

Parameters:
CLKS_PER_BIT, 139, clock cycles per bit (f_clk / baud); legal range 4..255, 8-bit bit-timer.

Ports:
i_Clock  in  1  system clock; all logic on rising edge.
i_Rst_n  in  1  reset; asynchronous assert, active-low.
i_Rx_Serial  in  1  asynchronous serial line; idles high.
o_Rx_DV  out  1  one-cycle pulse: o_Rx_Word holds a freshly received good word.
o_Rx_Word  out  16  last good word; bit 0 = first data bit on the line.
o_Rx_Error  out  1  one-cycle pulse: framing error (stop bit sampled low).
o_Rx_Active  out  1  high from start-bit detection until the frame ends or aborts.

Behaviour:
- Reset (i_Rst_n=0, asynchronous): state IDLE; o_Rx_DV=0, o_Rx_Error=0, o_Rx_Active=0, o_Rx_Word=16'h0000; synchroniser flops=1; bit timer=0; bit index=0; armed flag=0.
- Mid-frame reset aborts the frame immediately. No DV or Error pulse results from the aborted frame.
- Synchroniser: 2 flops on i_Rx_Serial. All decisions use the 2nd flop output (rx_s). Added latency: 2 cycles.
- Armed flag: set when rx_s=1 in IDLE. Cleared on reset and on framing error. A start is accepted only while armed, so a line held low through reset release or a break produces no frame.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: timer=0, index=0. If armed and rx_s=0, go to START and set o_Rx_Active=1.
- START: count timer to H=(CLKS_PER_BIT-1)/2 (integer division; 69 for 139).
  - At timer==H with rx_s=0: timer<=0, go to DATA.
  - At timer==H with rx_s=1: glitch. Go to IDLE, o_Rx_Active<=0, no pulses.
- DATA: count timer to CLKS_PER_BIT-1. At that count, shift-sample rx_s into bit[index] and set timer<=0.
  - index<15: index++.
  - index==15: index<=0, go to STOP.
  - Sampling points are mid-bit.
- STOP: at timer==CLKS_PER_BIT-1, sample rx_s:
  - rx_s=1: o_Rx_Word<=shift data, o_Rx_DV<=1 for exactly one cycle, o_Rx_Active<=0, go to IDLE.
  - rx_s=0: o_Rx_Error<=1 for one cycle, o_Rx_Word unchanged, o_Rx_Active<=0, armed<=0, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then set armed and go to IDLE.
- Back-to-back frames: IDLE is re-entered at mid-stop, so a start bit arriving immediately after the stop bit is caught (≥ half-bit margin).
- Latency: falling edge on i_Rx_Serial to o_Rx_DV = 2 + (H+1) + 17*CLKS_PER_BIT, ±1 cycle. For default 139: 2435 ±1 cycles.
- o_Rx_Word changes only on the same edge that o_Rx_DV rises. It holds its value otherwise, including across errors.
- o_Rx_DV and o_Rx_Error are never high in the same cycle.
- Timer width: 8 bits. Index width: 4 bits. No wrap is reachable within the legal parameter range.

Test Plan:
- Reset then idle-high line for 1000 cycles -> o_Rx_DV=0, o_Rx_Error=0, o_Rx_Active=0, o_Rx_Word=16'h0000 throughout.
- Bit-accurate frame of 16'hA55A at CLKS_PER_BIT=139 -> single o_Rx_DV pulse at 2435±1 cycles after start edge, o_Rx_Word=16'hA55A, o_Rx_Active high until that edge.
- Two back-to-back frames 16'h0001 then 16'hFFFE with no idle gap (CLKS_PER_BIT=8) -> two DV pulses exactly 18*8=144 cycles apart, words 16'h0001 then 16'hFFFE.
- Low glitch of 20 cycles on idle line (CLKS_PER_BIT=139) -> o_Rx_Active pulses ~70 cycles then drops, no DV/Error; a following frame 16'h1234 is received correctly.
- Frame 16'hBEEF with stop bit forced 0 and line held low 500 cycles -> one o_Rx_Error pulse, no DV, o_Rx_Word keeps the prior value. No new frame is recognised until the line goes high; a subsequent frame 16'h00FF is received correctly.
- Assert i_Rst_n low mid-DATA for 3 cycles with the line low at release -> outputs are reset asynchronously (before the next clock edge), no pulses occur, and no frame starts until the line has been high; the next good frame 16'h5A5A is received correctly.

Source files
------------

// File: rtl/uart_rx_16.sv
// uart_rx_16: receiver for 18-bit frames (start, 16 data LSB first, stop).
// Two-flop synchroniser, mid-bit sampling, one-cycle DV / error pulses.
module uart_rx_16 #(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_Serial,
  output logic        o_Rx_DV,
  output logic [15:0] o_Rx_Word,
  output logic        o_Rx_Error,
  output logic        o_Rx_Active
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);

  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic [1:0]  vld_q;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] word_q, word_d;
  logic        dv_q, dv_d;
  logic        err_q, err_d;
  logic        act_q, act_d;
  logic        armed_q, armed_d;
  logic        rx_s;
  logic        tick_h;
  logic        tick_b;

  assign rx_s   = sync_q[1];
  assign tick_h = (timer_q == HALF);
  assign tick_b = (timer_q == LAST);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      vld_q   <= 2'b00;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      act_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], i_Rx_Serial};
      vld_q   <= {vld_q[0], 1'b1};
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      act_q   <= act_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (armed_q && !rx_s) state_d = START;
      START:     if (tick_h) state_d = rx_s ? IDLE : DATA;
      DATA:      if (tick_b && idx_q == 4'd15) state_d = STOP;
      STOP:      if (tick_b) state_d = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    word_d  = word_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    act_d   = act_q;
    armed_d = armed_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        // sync flops hold reset ones for two cycles; ignore them
        if (rx_s && vld_q[1]) armed_d = 1'b1;
        if (armed_q && !rx_s) act_d = 1'b1;
      end
      START: begin
        if (tick_h) begin
          timer_d = '0;
          if (rx_s) act_d = 1'b0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      DATA: begin
        if (tick_b) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[15:1]};
          idx_d   = idx_q + 4'd1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      STOP: begin
        if (tick_b) begin
          timer_d = '0;
          act_d   = 1'b0;
          if (rx_s) begin
            word_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            err_d   = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      WAIT_HIGH: if (rx_s) armed_d = 1'b1;
      default: begin
        timer_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign o_Rx_DV     = dv_q;
  assign o_Rx_Word   = word_q;
  assign o_Rx_Error  = err_q;
  assign o_Rx_Active = act_q;

endmodule
